program_memory_sync: RTL and testbench
======================================

Name: program_memory_sync

Overview:
- Clocked, parametrised successor to the combinational instruction ROM.
- Holds the program for the mini-processor in a DEPTH-word array of INSTR_WIDTH-bit instructions.
- Fetch port: registered, 1-cycle latency, with stall support. Load port: host writes a program at run time.
- Post-reset clear sequencer fills the array with FILL_WORD before fetches are accepted.

Parameters:
- INSTR_WIDTH, 28, instruction word width (8-bit opcode plus 20-bit operand field at default).
- ADDR_WIDTH, 16, width of fetch and load addresses.
- DEPTH, 256, number of implemented words; must be ≤ 2**ADDR_WIDTH.
- FILL_WORD, {NOP opcode, 20'd0}, word written by the clear sequencer and returned on out-of-range fetch.
- CLEAR_ON_RESET, 1, 1 = run the clear sequence after every reset; 0 = go straight to READY with array contents undefined.

Ports:
- Clock  input  1  system clock; all state updates on the rising edge.
- Reset  input  1  synchronous, active-high reset.
- iFetchValid  input  1  fetch request this cycle.
- iAddress  input  ADDR_WIDTH  fetch address.
- iStall  input  1  hold oInstruction/oValid; the request is not consumed.
- oInstruction  output  INSTR_WIDTH  fetched word (registered).
- oValid  output  1  oInstruction holds the result of an accepted fetch.
- oAddrFault  output  1  the accepted fetch had iAddress ≥ DEPTH.
- iWriteEnable  input  1  load-port write strobe.
- iWriteAddress  input  ADDR_WIDTH  load address.
- iWriteData  input  INSTR_WIDTH  load data.
- oReady  output  1  clear sequence finished; fetches and writes accepted.

Behaviour:
- Reset (synchronous, dominates all inputs):
  - oInstruction = FILL_WORD, oValid = 0, oAddrFault = 0, oReady = 0.
  - Clear counter = 0.
  - State = CLEAR if CLEAR_ON_RESET = 1, otherwise READY.
- State CLEAR:
  - Each cycle writes FILL_WORD to array[counter], then counter++.
  - After the write to DEPTH-1, go to READY next cycle; oReady rises that same edge.
  - Clear takes exactly DEPTH cycles after Reset deasserts.
  - iFetchValid and iWriteEnable are ignored; oValid stays 0.
- State READY (oReady = 1):
  - Fetch accepted when iFetchValid = 1 and iStall = 0. The next edge loads:
    - oInstruction = array[iAddress] when iAddress < DEPTH;
    - otherwise oInstruction = FILL_WORD and oAddrFault = 1.
  - oValid = 1 on that edge.
  - iStall = 1: oInstruction, oValid and oAddrFault hold their values regardless of iFetchValid.
  - iFetchValid = 0 and iStall = 0: oValid = 0, oAddrFault = 0, oInstruction holds.
- Load port:
  - Write committed at the edge when iWriteEnable = 1 and iWriteAddress < DEPTH.
  - Writes to iWriteAddress ≥ DEPTH are dropped silently.
  - Writes are accepted in READY only.
- Same-cycle collision (accepted fetch and committed write to the same address):
  - Write-first: oInstruction = iWriteData.
- Address compare:
  - Full ADDR_WIDTH compare against DEPTH; no wrap-around or aliasing.
  - Index uses the low $clog2(DEPTH) bits only after the range check passes.
- Reset asserted mid-CLEAR or mid-fetch:
  - Outputs return to reset values and the clear restarts from address 0.
  - Contents written before the reset are not guaranteed when CLEAR_ON_RESET = 1.
- No operation alters oReady once it is 1, except Reset.

Decomposition:
- Shared definitions file (alongside existing opcode defines):
  - opcode field width and position;
  - NOP encoding used to build FILL_WORD;
  - state encodings CLEAR = 1'b0, READY = 1'b1.
- One sub-module, program_memory_array:
  - single-write/single-read synchronous array, parametrised INSTR_WIDTH/DEPTH;
  - write-first read behaviour.
- Parent owns the clear FSM, range checks, stall hold and output registers.

Test Plan:
- Reset with DEPTH=16, CLEAR_ON_RESET=1 → oReady low for 16 cycles, high on cycle 16; fetches of 0..15 return FILL_WORD, oValid 1 cycle after each request.
- Write 0x1234567 to addr 3, then fetch addr 3 next cycle → oInstruction = 0x1234567, oValid = 1, oAddrFault = 0.
- Fetch addr 3 while writing 0x0ABCDEF to addr 3 in the same cycle → oInstruction = 0x0ABCDEF (write-first).
- Fetch addr 20 with DEPTH=16 → oInstruction = FILL_WORD, oAddrFault = 1. Write to addr 20, then fetch addr 4 → addr-4 contents unchanged (no aliasing).
- Fetch addr 5, then iStall = 1 for 3 cycles while iAddress changes to 6 → oInstruction stays at addr-5 data and oValid stays 1; on release, addr 6 is fetched.
- Assert Reset at clear cycle 7, release → clear restarts; oReady high exactly 16 cycles after release; earlier writes/fetches produce no oValid during CLEAR.

Source files
------------

// File: rtl/program_memory_sync_pkg.sv
// Shared definitions for the mini-processor program memory: opcode field
// layout, the NOP encoding used to build the fill word, and sequencer states.
package program_memory_sync_pkg;

  localparam int unsigned OPCODE_WIDTH = 8;
  localparam int unsigned OPERAND_WIDTH = 20;
  // Opcode occupies the top OPCODE_WIDTH bits of the instruction word.
  localparam int unsigned OPCODE_LSB = OPERAND_WIDTH;

  localparam logic [OPCODE_WIDTH-1:0] NOP_OPCODE = 8'h0F;

  // Sequencer state encodings.
  localparam logic [0:0] ST_CLEAR = 1'b0;
  localparam logic [0:0] ST_READY = 1'b1;

  // Index width for an array of the given depth (at least one bit).
  function automatic int unsigned idx_width(input int unsigned depth);
    return (depth > 1) ? $clog2(depth) : 1;
  endfunction

endpackage

// File: rtl/program_memory_array.sv
// Single-write / single-read instruction array. Writes land on the rising
// edge; the read port is combinational with write-first bypass so the parent
// can register the fetched word and see same-cycle load data.
module program_memory_array #(
  parameter int unsigned INSTR_WIDTH = 28,
  parameter int unsigned DEPTH       = 256,
  parameter int unsigned IDX_W       = 8
) (
  input  logic                   clk_i,
  input  logic                   we_i,
  input  logic [IDX_W-1:0]       waddr_i,
  input  logic [INSTR_WIDTH-1:0] wdata_i,
  input  logic [IDX_W-1:0]       raddr_i,
  output logic [INSTR_WIDTH-1:0] rdata_c
);

  logic [INSTR_WIDTH-1:0] mem_q [DEPTH];

  // Storage update from the single write port.
  always_ff @(posedge clk_i) begin
    if (we_i) begin
      mem_q[waddr_i] <= wdata_i;
    end
  end

  // Write-first read: a write to the address being read wins.
  always_comb begin
    rdata_c = mem_q[raddr_i];
    if (we_i && (waddr_i == raddr_i)) begin
      rdata_c = wdata_i;
    end
  end

endmodule

// File: rtl/program_memory_sync.sv
// Clocked program memory: clear sequencer after reset, registered fetch port
// with stall hold and range fault, and a run-time load port.
module program_memory_sync
  import program_memory_sync_pkg::*;
#(
  parameter int unsigned            INSTR_WIDTH    = 28,
  parameter int unsigned            ADDR_WIDTH     = 16,
  parameter int unsigned            DEPTH          = 256,
  parameter logic [INSTR_WIDTH-1:0] FILL_WORD      =
    INSTR_WIDTH'(NOP_OPCODE) << (INSTR_WIDTH - OPCODE_WIDTH),
  parameter bit                     CLEAR_ON_RESET = 1'b1
) (
  input  logic                   Clock,
  input  logic                   Reset,
  input  logic                   iFetchValid,
  input  logic [ADDR_WIDTH-1:0]  iAddress,
  input  logic                   iStall,
  output logic [INSTR_WIDTH-1:0] oInstruction,
  output logic                   oValid,
  output logic                   oAddrFault,
  input  logic                   iWriteEnable,
  input  logic [ADDR_WIDTH-1:0]  iWriteAddress,
  input  logic [INSTR_WIDTH-1:0] iWriteData,
  output logic                   oReady
);

  localparam int unsigned IDX_W = idx_width(DEPTH);
  // DEPTH fits in ADDR_WIDTH+1 bits because DEPTH <= 2**ADDR_WIDTH.
  localparam logic [ADDR_WIDTH:0] DEPTH_CMP = (ADDR_WIDTH + 1)'(DEPTH);
  localparam logic [IDX_W-1:0]    LAST_IDX  = IDX_W'(DEPTH - 1);
  localparam logic [0:0]          RST_STATE = CLEAR_ON_RESET ? ST_CLEAR : ST_READY;

  logic [0:0]             state_q, state_d;
  logic [IDX_W-1:0]       count_q, count_d;
  logic [INSTR_WIDTH-1:0] instr_q, instr_d;
  logic                   valid_q, valid_d;
  logic                   fault_q, fault_d;
  logic                   ready_q, ready_d;

  logic                   rd_in_range_c;
  logic                   wr_in_range_c;
  logic                   mem_we_c;
  logic [IDX_W-1:0]       mem_waddr_c;
  logic [INSTR_WIDTH-1:0] mem_wdata_c;
  logic [INSTR_WIDTH-1:0] mem_rdata_c;

  // Full-width range checks; no aliasing of high address bits.
  assign rd_in_range_c = ({1'b0, iAddress} < DEPTH_CMP);
  assign wr_in_range_c = ({1'b0, iWriteAddress} < DEPTH_CMP);

  program_memory_array #(
    .INSTR_WIDTH (INSTR_WIDTH),
    .DEPTH       (DEPTH),
    .IDX_W       (IDX_W)
  ) u_array (
    .clk_i   (Clock),
    .we_i    (mem_we_c),
    .waddr_i (mem_waddr_c),
    .wdata_i (mem_wdata_c),
    .raddr_i (IDX_W'(iAddress)),
    .rdata_c (mem_rdata_c)
  );

  // Next-state, array write steering and output updates.
  always_comb begin
    state_d     = state_q;
    count_d     = count_q;
    instr_d     = instr_q;
    valid_d     = valid_q;
    fault_d     = fault_q;
    ready_d     = ready_q;
    mem_we_c    = 1'b0;
    mem_waddr_c = IDX_W'(iWriteAddress);
    mem_wdata_c = iWriteData;

    case (state_q)
      ST_CLEAR: begin
        mem_we_c    = 1'b1;
        mem_waddr_c = count_q;
        mem_wdata_c = FILL_WORD;
        valid_d     = 1'b0;
        fault_d     = 1'b0;
        if (count_q == LAST_IDX) begin
          state_d = ST_READY;
          ready_d = 1'b1;
        end else begin
          count_d = count_q + IDX_W'(1);
        end
      end
      default: begin
        ready_d  = 1'b1;
        mem_we_c = iWriteEnable && wr_in_range_c;
        if (!iStall) begin
          if (iFetchValid) begin
            valid_d = 1'b1;
            if (rd_in_range_c) begin
              instr_d = mem_rdata_c;
              fault_d = 1'b0;
            end else begin
              instr_d = FILL_WORD;
              fault_d = 1'b1;
            end
          end else begin
            valid_d = 1'b0;
            fault_d = 1'b0;
          end
        end
      end
    endcase
  end

  // State and output registers with synchronous reset.
  always_ff @(posedge Clock) begin
    if (Reset) begin
      state_q <= RST_STATE;
      count_q <= '0;
      instr_q <= FILL_WORD;
      valid_q <= 1'b0;
      fault_q <= 1'b0;
      ready_q <= 1'b0;
    end else begin
      state_q <= state_d;
      count_q <= count_d;
      instr_q <= instr_d;
      valid_q <= valid_d;
      fault_q <= fault_d;
      ready_q <= ready_d;
    end
  end

  assign oInstruction = instr_q;
  assign oValid       = valid_q;
  assign oAddrFault   = fault_q;
  assign oReady       = ready_q;

endmodule

// File: tb/tb_program_memory_sync.sv
// Directed bench for program_memory_sync (DEPTH=16) with an expected-output
// scoreboard and a small behavioural memory model.
module tb_program_memory_sync;

  localparam int unsigned DEPTH = 16;
  localparam logic [27:0] FILL  = 28'h0F0_0000;

  typedef struct packed {
    logic [27:0] instr;
    logic        valid;
    logic        fault;
  } exp_t;

  logic        Clock;
  logic        Reset;
  logic        iFetchValid;
  logic [15:0] iAddress;
  logic        iStall;
  logic [27:0] oInstruction;
  logic        oValid;
  logic        oAddrFault;
  logic        iWriteEnable;
  logic [15:0] iWriteAddress;
  logic [27:0] iWriteData;
  logic        oReady;

  int checks = 0;
  int errors = 0;

  exp_t        sb_q[$];
  logic [27:0] model [DEPTH];
  exp_t        exp_out;

  program_memory_sync #(
    .INSTR_WIDTH    (28),
    .ADDR_WIDTH     (16),
    .DEPTH          (DEPTH),
    .CLEAR_ON_RESET (1'b1)
  ) dut (
    .Clock         (Clock),
    .Reset         (Reset),
    .iFetchValid   (iFetchValid),
    .iAddress      (iAddress),
    .iStall        (iStall),
    .oInstruction  (oInstruction),
    .oValid        (oValid),
    .oAddrFault    (oAddrFault),
    .iWriteEnable  (iWriteEnable),
    .iWriteAddress (iWriteAddress),
    .iWriteData    (iWriteData),
    .oReady        (oReady)
  );

  initial Clock = 1'b0;
  always #5 Clock = ~Clock;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic cycle();
    @(posedge Clock);
    #1;
  endtask

  task automatic idle_inputs();
    iFetchValid   = 1'b0;
    iAddress      = '0;
    iStall        = 1'b0;
    iWriteEnable  = 1'b0;
    iWriteAddress = '0;
    iWriteData    = '0;
  endtask

  // Hold reset for n edges, check reset outputs, then wait out the clear.
  task automatic reset_and_clear(input string tag, input int n);
    Reset = 1'b1;
    repeat (n) cycle();
    chk({tag, "_rst_instr"}, 32'(oInstruction), 32'(FILL));
    chk({tag, "_rst_valid"}, 32'(oValid), 32'd0);
    chk({tag, "_rst_fault"}, 32'(oAddrFault), 32'd0);
    chk({tag, "_rst_ready"}, 32'(oReady), 32'd0);
    Reset = 1'b0;
    // Requests during the clear must be ignored.
    iFetchValid   = 1'b1;
    iAddress      = 16'd2;
    iWriteEnable  = 1'b1;
    iWriteAddress = 16'd2;
    iWriteData    = 28'h7777777;
    for (int i = 1; i <= int'(DEPTH); i++) begin
      cycle();
      chk($sformatf("%s_ready_c%0d", tag, i), 32'(oReady), (i == int'(DEPTH)) ? 32'd1 : 32'd0);
      chk($sformatf("%s_valid_c%0d", tag, i), 32'(oValid), 32'd0);
    end
    idle_inputs();
    for (int i = 0; i < int'(DEPTH); i++) model[i] = FILL;
    exp_out = '{instr: FILL, valid: 1'b0, fault: 1'b0};
  endtask

  // One READY-state cycle: predict outputs, push, clock, pop and compare.
  task automatic step(input string tag, input logic fv, input logic [15:0] addr,
                      input logic stall, input logic we, input logic [15:0] wa,
                      input logic [27:0] wd);
    exp_t got_exp;
    iFetchValid   = fv;
    iAddress      = addr;
    iStall        = stall;
    iWriteEnable  = we;
    iWriteAddress = wa;
    iWriteData    = wd;
    if (!stall) begin
      if (fv) begin
        exp_out.valid = 1'b1;
        if (32'(addr) < DEPTH) begin
          exp_out.instr = (we && wa == addr) ? wd : model[addr[3:0]];
          exp_out.fault = 1'b0;
        end else begin
          exp_out.instr = FILL;
          exp_out.fault = 1'b1;
        end
      end else begin
        exp_out.valid = 1'b0;
        exp_out.fault = 1'b0;
      end
    end
    sb_q.push_back(exp_out);
    cycle();
    got_exp = sb_q.pop_front();
    chk({tag, "_instr"}, 32'(oInstruction), 32'(got_exp.instr));
    chk({tag, "_valid"}, 32'(oValid), 32'(got_exp.valid));
    chk({tag, "_fault"}, 32'(oAddrFault), 32'(got_exp.fault));
    chk({tag, "_ready"}, 32'(oReady), 32'd1);
    if (we && 32'(wa) < DEPTH) model[wa[3:0]] = wd;
    idle_inputs();
  endtask

  initial begin
    idle_inputs();
    Reset = 1'b1;
    reset_and_clear("init", 2);

    // Cleared contents, including the address written during the clear.
    for (int a = 0; a < int'(DEPTH); a++)
      step($sformatf("clr_fetch%0d", a), 1'b1, 16'(a), 1'b0, 1'b0, '0, '0);
    step("idle", 1'b0, '0, 1'b0, 1'b0, '0, '0);

    // Load then fetch.
    step("wr3", 1'b0, '0, 1'b0, 1'b1, 16'd3, 28'h1234567);
    step("rd3", 1'b1, 16'd3, 1'b0, 1'b0, '0, '0);

    // Same-cycle write and fetch: write-first.
    step("coll3", 1'b1, 16'd3, 1'b0, 1'b1, 16'd3, 28'h0ABCDEF);
    step("rd3b", 1'b1, 16'd3, 1'b0, 1'b0, '0, '0);

    // Range boundaries and no aliasing.
    step("wr4", 1'b0, '0, 1'b0, 1'b1, 16'd4, 28'h4444444);
    step("wr15", 1'b0, '0, 1'b0, 1'b1, 16'd15, 28'h0F0F0F1);
    step("rd15", 1'b1, 16'd15, 1'b0, 1'b0, '0, '0);
    step("rd16", 1'b1, 16'd16, 1'b0, 1'b0, '0, '0);
    step("rd20", 1'b1, 16'd20, 1'b0, 1'b0, '0, '0);
    step("rdhigh", 1'b1, 16'hFFF4, 1'b0, 1'b0, '0, '0);
    step("wr20", 1'b0, '0, 1'b0, 1'b1, 16'd20, 28'hDEAD000);
    step("rd4", 1'b1, 16'd4, 1'b0, 1'b0, '0, '0);
    step("idle2", 1'b0, '0, 1'b0, 1'b0, '0, '0);

    // Stall holds the fetched word while the address changes.
    step("wr5", 1'b0, '0, 1'b0, 1'b1, 16'd5, 28'h5555555);
    step("wr6", 1'b0, '0, 1'b0, 1'b1, 16'd6, 28'h6666666);
    step("rd5", 1'b1, 16'd5, 1'b0, 1'b0, '0, '0);
    for (int s = 0; s < 3; s++)
      step($sformatf("stall%0d", s), 1'b1, 16'd6, 1'b1, 1'b0, '0, '0);
    step("rd6", 1'b1, 16'd6, 1'b0, 1'b0, '0, '0);
    // Stall also holds a fault.
    step("rd17", 1'b1, 16'd17, 1'b0, 1'b0, '0, '0);
    step("stallf", 1'b0, 16'd1, 1'b1, 1'b0, '0, '0);

    // Reset part-way through a clear restarts it from address 0.
    Reset = 1'b1;
    cycle();
    Reset = 1'b0;
    for (int i = 1; i <= 7; i++) begin
      cycle();
      chk($sformatf("midclr_ready%0d", i), 32'(oReady), 32'd0);
    end
    reset_and_clear("midclr", 1);
    step("post3", 1'b1, 16'd3, 1'b0, 1'b0, '0, '0);
    step("post6", 1'b1, 16'd6, 1'b0, 1'b0, '0, '0);

    chk("sb_empty", 32'(sb_q.size()), 32'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
